reg_file_bank: RTL and testbench
================================

# reg_file_bank

Storage stage of the register file. It sits directly downstream of the write-enable decoder and consumes the decoder's 8-bit one-hot `wEn` vector. It holds eight `DATA_W`-bit registers and serves two asynchronous read ports with write-through bypass. It also provides a sequenced bulk-clear engine and a sticky error flag for a malformed (multi-hot) enable vector.

## Interface
- `DATA_W`, default 8: width of each register and of all data ports.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wEn`  in  8  one-hot write enable from the decoder; bit k selects register k.
- `wData`  in  DATA_W  write data.
- `rAddrA`  in  3  read address, port A.
- `rAddrB`  in  3  read address, port B.
- `rDataA`  out  DATA_W  read data, port A (combinational).
- `rDataB`  out  DATA_W  read data, port B (combinational).
- `clr`  in  1  bulk-clear request, sampled on the clock edge.
- `busy`  out  1  high while the clear engine runs.
- `wr_drop`  out  1  registered one-cycle pulse: a write was discarded.
- `err`  out  1  sticky flag: multi-hot `wEn` seen.
- `err_clr`  in  1  clears `err`.

## Operation
- **Registers.** `reg[0..7]` are `DATA_W` bits each and reset to 0.
- **Write classification** (IDLE state only):
  - `wEn` == 0: no write.
  - Exactly one bit k set: `reg[k]` <= `wData` on the edge.
  - Two or more bits set: no register changes; `err` <= 1.
- **Clear FSM.** States are IDLE and CLEAR, with a 3-bit counter `cnt`.
  - IDLE to CLEAR: `clr`=1 sampled; `cnt` <= 0.
  - In CLEAR, each edge: `reg[cnt]` <= 0 and `cnt` <= `cnt`+1.
  - The edge with `cnt`=7 clears `reg[7]` and returns to IDLE.
  - `busy` = (state == CLEAR).
  - `clr` during CLEAR is ignored; it does not restart or extend the sweep.
- **Writes during CLEAR.**
  - Any `wEn` != 0 is discarded and `wr_drop` pulses high on the following cycle.
  - A multi-hot `wEn` during CLEAR still sets `err`.
- **Reads.**
  - `rDataA` = `reg[rAddrA]` and `rDataB` = `reg[rAddrB]`, combinational.
  - Bypass: if a legal one-hot write to register k is accepted this cycle and rAddrX == k, rDataX = `wData`. Both ports may bypass at once.
  - There is no bypass in CLEAR; reads return stored contents.
- **err.**
  - Set by a multi-hot `wEn`; cleared only by `err_clr`.
  - Set wins if `err_clr` and a multi-hot `wEn` arrive on the same edge.
- **Reset** (asynchronous, any time, including mid-clear): all registers 0, state IDLE, `cnt` 0, `busy` 0, `wr_drop` 0, `err` 0.

## Timing
- **Write latency.** A written value is visible through the register path on the cycle after the edge. It is visible through the bypass in the same cycle.
- **Clear timing.**
  - `busy` rises after the edge that samples `clr`.
  - `reg[k]` reads 0 after clear edge k+1 (k = 0..7).
  - `busy` falls after the 8th clear edge, so it is high for exactly 8 cycles.
  - A write presented on the first cycle `busy` is low is accepted.
- **Write on the clr edge.** A legal write in the same cycle that `clr` is sampled in IDLE is accepted. The sweep then zeroes that register later anyway.
- **wr_drop.** One cycle per discarded write, never stretched.
- **err.** Registered; rises on the edge after the offending `wEn`.
- **Outputs after reset release.** `rDataA`/`rDataB` = 0, `busy`=0, `err`=0, `wr_drop`=0.

## Test plan
- **Write/read sweep:** reset, then write `wData`=8'h10+k with `wEn`=1<<k for k=0..7. Read all addresses on both ports: register k must read 8'h10+k, and port A/B must agree.
- **Bypass:** with `rAddrA`=3, drive `wEn`=8'h08 and `wData`=8'hA5. `rDataA`=8'hA5 in the same cycle; `reg[3]`=8'hA5 after the edge.
- **Multi-hot:** drive `wEn`=8'h81 with `wData`=8'hFF. Registers 0 and 7 are unchanged and `err`=1.
  - Assert `err_clr` alongside `wEn`=8'h03: `err` stays 1.
  - Assert `err_clr` alone: `err`=0.
- **Bulk clear:** load all registers with 8'hFF, pulse `clr`.
  - `busy` is high for exactly 8 cycles and `reg[k]`=0 after edge k+1.
  - A write `wEn`=8'h04 in CLEAR is discarded and `wr_drop` pulses once.
  - A second `clr` mid-sweep does not extend `busy`.
- **Reset mid-clear:** assert `reset_n`=0 at `cnt`=4. Immediately `busy`=0 and all registers 0; after release the FSM is in IDLE and the next write is accepted.

Source files
------------

// File: rtl/reg_file_bank_if.sv
// Bus between the write-enable decoder / read clients and the register file storage bank.
interface reg_file_bank_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        wEn;
  logic [DATA_W-1:0] wData;
  logic [2:0]        rAddrA;
  logic [2:0]        rAddrB;
  logic [DATA_W-1:0] rDataA;
  logic [DATA_W-1:0] rDataB;
  logic              clr;
  logic              busy;
  logic              wr_drop;
  logic              err;
  logic              err_clr;

  modport master (
    output wEn, wData, rAddrA, rAddrB, clr, err_clr,
    input  rDataA, rDataB, busy, wr_drop, err
  );

  modport slave (
    input  wEn, wData, rAddrA, rAddrB, clr, err_clr,
    output rDataA, rDataB, busy, wr_drop, err
  );
endinterface

// File: rtl/reg_file_bank.sv
// Eight-entry register storage with two bypassed async read ports, a sequenced
// bulk-clear sweep and a sticky flag for multi-hot write enables.
module reg_file_bank #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  reg_file_bank_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];
  logic              wr_drop_q, wr_drop_d;
  logic              err_q, err_d;

  logic              any_en;
  logic              one_hot;
  logic              multi_hot;
  logic              write_ok;
  logic [2:0]        wr_idx;

  // An enable is legal only when exactly one bit is set.
  always_comb begin
    any_en    = |bus.wEn;
    one_hot   = any_en && ((bus.wEn & (bus.wEn - 8'd1)) == 8'd0);
    multi_hot = any_en && !one_hot;
    wr_idx    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (bus.wEn[k]) begin
        wr_idx = 3'(k);
      end
    end
    write_ok  = (state_q == IDLE) && one_hot;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = 3'd0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Writes and the sweep are mutually exclusive since writes only land in IDLE.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      regs_d[k] = regs_q[k];
    end
    if (write_ok) begin
      regs_d[wr_idx] = bus.wData;
    end
    if (state_q == CLEAR) begin
      regs_d[cnt_q] = '0;
    end
  end

  always_comb begin
    wr_drop_d = (state_q == CLEAR) && any_en;
    if (multi_hot) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      wr_drop_q <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
      err_q     <= err_d;
      for (int k = 0; k < 8; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  assign bus.rDataA  = (write_ok && (wr_idx == bus.rAddrA)) ? bus.wData : regs_q[bus.rAddrA];
  assign bus.rDataB  = (write_ok && (wr_idx == bus.rAddrB)) ? bus.wData : regs_q[bus.rAddrB];
  assign bus.busy    = (state_q == CLEAR);
  assign bus.wr_drop = wr_drop_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// Scoreboard bench for reg_file_bank: expectations are queued as stimulus is
// driven and popped against the DUT outputs when they are sampled.
module tb_reg_file_bank;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  reg_file_bank_if #(.DATA_W(8)) bus();

  reg_file_bank #(.DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t       sbQ [$];
  logic [7:0] mReg [8];
  int         nCompared   = 0;
  int         nMismatched = 0;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pushExp(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sbQ.push_back(e);
  endtask

  task automatic popCheck(input logic [15:0] obs);
    exp_t e;
    if (sbQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL sb_underflow: got %0h expected nothing", obs);
    end else begin
      e = sbQ.pop_front();
      checkOutput(e.tag, obs, e.exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] en, input logic [7:0] d, input logic c, input logic ec);
    @(negedge clk);
    bus.wEn     = en;
    bus.wData   = d;
    bus.clr     = c;
    bus.err_clr = ec;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readExp(input logic [2:0] a, input logic [2:0] b,
                         input logic [7:0] expA, input logic [7:0] expB, input string tag);
    pushExp({tag, "_A"}, {8'h00, expA});
    pushExp({tag, "_B"}, {8'h00, expB});
    bus.rAddrA = a;
    bus.rAddrB = b;
    #1;
    popCheck({8'h00, bus.rDataA});
    popCheck({8'h00, bus.rDataB});
  endtask

  task automatic readCheck(input logic [2:0] a, input logic [2:0] b, input string tag);
    readExp(a, b, mReg[a], mReg[b], tag);
  endtask

  task automatic scalarCheck(input string tag, input logic obs, input logic exp);
    pushExp(tag, {15'd0, exp});
    popCheck({15'd0, obs});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    bus.wEn     = 8'h00;
    bus.wData   = 8'h00;
    bus.clr     = 1'b0;
    bus.err_clr = 1'b0;
    bus.rAddrA  = 3'd0;
    bus.rAddrB  = 3'd0;
    for (int k = 0; k < 8; k++) mReg[k] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    scalarCheck("rst_busy", bus.busy, 1'b0);
    scalarCheck("rst_err", bus.err, 1'b0);
    scalarCheck("rst_wr_drop", bus.wr_drop, 1'b0);
    readCheck(3'd0, 3'd7, "rst_read");

    @(negedge clk);
    reset_n = 1'b1;
    tick();
    scalarCheck("rel_busy", bus.busy, 1'b0);
    scalarCheck("rel_err", bus.err, 1'b0);
    readCheck(3'd2, 3'd5, "rel_read");

    // Write/read sweep
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'h01 << k, 8'h10 + 8'(k), 1'b0, 1'b0);
      tick();
      mReg[k] = 8'h10 + 8'(k);
    end
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      readCheck(3'(k), 3'(7 - k), "sweep");
      readCheck(3'(k), 3'(k), "agree");
    end

    // Bypass on port A, port B reading a different register
    applyStimulus(8'h08, 8'hA5, 1'b0, 1'b0);
    readExp(3'd3, 3'd2, 8'hA5, mReg[2], "bypass");
    readExp(3'd3, 3'd3, 8'hA5, 8'hA5, "bypass_both");
    tick();
    mReg[3] = 8'hA5;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    readCheck(3'd3, 3'd4, "after_bypass");

    // Multi-hot enables
    applyStimulus(8'h81, 8'hFF, 1'b0, 1'b0);
    readExp(3'd0, 3'd7, mReg[0], mReg[7], "mh_no_bypass");
    tick();
    scalarCheck("mh_err", bus.err, 1'b1);
    readCheck(3'd0, 3'd7, "mh_unchanged");
    applyStimulus(8'h03, 8'hEE, 1'b0, 1'b1);
    tick();
    scalarCheck("err_set_wins", bus.err, 1'b1);
    readCheck(3'd0, 3'd1, "mh2_unchanged");
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    scalarCheck("err_cleared", bus.err, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    scalarCheck("err_stays_clear", bus.err, 1'b0);

    // Bulk clear with a dropped write and a redundant clr mid-sweep
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'h01 << k, 8'hFF, 1'b0, 1'b0);
      tick();
      mReg[k] = 8'hFF;
    end
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    scalarCheck("busy_rise", bus.busy, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      if (e == 3) begin
        applyStimulus(8'h04, 8'hAA, 1'b0, 1'b0);
        readExp(3'd2, 3'd2, 8'hFF, 8'hFF, "clr_no_bypass");
      end else if (e == 5) begin
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
      end else begin
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      end
      tick();
      mReg[e - 1] = 8'h00;
      scalarCheck("busy_sweep", bus.busy, e < 8);
      scalarCheck("wr_drop_sweep", bus.wr_drop, e == 3);
      readCheck(3'(e - 1), 3'(e), "clr_edge");
    end
    applyStimulus(8'h20, 8'h5A, 1'b0, 1'b0);
    readExp(3'd5, 3'd4, 8'h5A, mReg[4], "first_idle_write");
    tick();
    mReg[5] = 8'h5A;
    scalarCheck("wr_drop_idle", bus.wr_drop, 1'b0);
    scalarCheck("busy_idle", bus.busy, 1'b0);
    readCheck(3'd5, 3'd4, "after_clear");

    // Write on the clr edge, then reset in the middle of the sweep
    applyStimulus(8'h02, 8'h77, 1'b1, 1'b0);
    tick();
    mReg[1] = 8'h77;
    scalarCheck("busy_clr_write", bus.busy, 1'b1);
    readCheck(3'd1, 3'd5, "clr_edge_write");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      mReg[i] = 8'h00;
    end
    readCheck(3'd1, 3'd5, "pre_reset");
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) mReg[k] = 8'h00;
    scalarCheck("mid_rst_busy", bus.busy, 1'b0);
    scalarCheck("mid_rst_err", bus.err, 1'b0);
    for (int k = 0; k < 8; k += 2) begin
      readCheck(3'(k), 3'(k + 1), "mid_rst_read");
    end
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(8'h40, 8'h3C, 1'b0, 1'b0);
    tick();
    mReg[6] = 8'h3C;
    scalarCheck("post_rst_busy", bus.busy, 1'b0);
    scalarCheck("post_rst_drop", bus.wr_drop, 1'b0);
    readCheck(3'd6, 3'd5, "post_rst_write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
